// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial N-bit subtractor with a start/busy/done handshake.
// It computes {bout,diff} = a - b - bin one bit per clock, LSB first, from
// latched copies of the operands. Results are held until the next completion.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   res_q, res_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           br_q, br_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   diff_q, diff_d;
  logic           bout_q, bout_d;

  logic           a_bit;
  logic           b_bit;
  logic           diff_bit;
  logic           br_next;
  logic [N-1:0]   res_shift;

  // Next-state logic: accept in IDLE/DONE, consume one bit per RUN edge,
  // and publish diff/bout only on the final bit.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    br_d      = br_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    diff_d    = diff_q;
    bout_d    = bout_q;

    a_bit     = a_q[0];
    b_bit     = b_q[0];
    diff_bit  = a_bit ^ b_bit ^ br_q;
    br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    res_shift = {diff_bit, res_q[N-1:1]};

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          res_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_next;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          diff_d  = res_shift;
          bout_d  = br_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: drives an N=8 and an N=4 instance; expected results are
// queued when an operation is launched and compared whenever done pulses.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [8:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  int         errors = 0;
  int         checks = 0;
  int         dones8 = 0, dones4 = 0, pushes8 = 0, pushes4 = 0;
  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic [8:0] exp8_m;
  logic [4:0] exp4_m;

  vec_t       tbl8[10];
  vec_t       tbl4[6];

  // 100 MHz free-running clock shared by both instances.
  always #5 clk = ~clk;

  serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {8'b0, bin};
  endfunction

  function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {4'b0, bin};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Drive one request at a falling edge and return just after the accepting edge.
  task automatic applyStimulus(input bit use4, input logic [7:0] a, input logic [7:0] b,
                               input logic bin, input logic [8:0] exp, input bit expect_done);
    @(negedge clk);
    if (use4) begin
      a4 = a[3:0]; b4 = b[3:0]; bin4 = bin; start4 = 1'b1;
      if (expect_done) begin q4.push_back(exp[4:0]); pushes4++; end
    end else begin
      a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
      if (expect_done) begin q8.push_back(exp); pushes8++; end
    end
    @(posedge clk);
  endtask

  // Count falling edges after acceptance until done, with a bounded wait.
  task automatic waitDone(input bit use4, output int k, output int busy_cycles);
    bit seen;
    seen = 1'b0;
    k = 0;
    busy_cycles = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin start8 = 1'b0; start4 = 1'b0; end
      if (use4 ? busy4 : busy8) busy_cycles++;
      if (use4 ? done4 : done8) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: actual=no_done required=done");
    end
  endtask

  // Scoreboard: every done pulse pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done8) begin
        dones8++;
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_done8: actual=1 required=0");
        end else begin
          exp8_m = q8.pop_front();
          checkOutput("diff8", 32'(diff8), 32'(exp8_m[7:0]));
          checkOutput("bout8", 32'(bout8), 32'(exp8_m[8]));
        end
      end
      if (done4) begin
        dones4++;
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_done4: actual=1 required=0");
        end else begin
          exp4_m = q4.pop_front();
          checkOutput("diff4", 32'(diff4), 32'(exp4_m[3:0]));
          checkOutput("bout4", 32'(bout4), 32'(exp4_m[4]));
        end
      end
    end
  end

  // Main sequence: reset, directed table, corner-case sequences, random regression.
  initial begin
    int k, bc, d0, gap;
    logic [7:0] ra, rb;
    logic rbin;

    tbl8[0] = '{8'd8,   8'd3,   1'b0, 9'h005};
    tbl8[1] = '{8'd0,   8'd1,   1'b0, 9'h1FF};
    tbl8[2] = '{8'd5,   8'd5,   1'b1, 9'h1FF};
    tbl8[3] = '{8'd200, 8'd100, 1'b0, 9'h064};
    tbl8[4] = '{8'd0,   8'd0,   1'b0, 9'h000};
    tbl8[5] = '{8'd255, 8'd255, 1'b1, 9'h1FF};
    tbl8[6] = '{8'd255, 8'd0,   1'b0, 9'h0FF};
    tbl8[7] = '{8'd0,   8'd255, 1'b0, 9'h101};
    tbl8[8] = '{8'd128, 8'd1,   1'b0, 9'h07F};
    tbl8[9] = '{8'd0,   8'd0,   1'b1, 9'h1FF};

    tbl4[0] = '{8'd3,  8'd7,  1'b0, 9'h01C};
    tbl4[1] = '{8'd15, 8'd0,  1'b1, 9'h00E};
    tbl4[2] = '{8'd0,  8'd1,  1'b0, 9'h01F};
    tbl4[3] = '{8'd15, 8'd15, 1'b1, 9'h01F};
    tbl4[4] = '{8'd8,  8'd1,  1'b0, 9'h007};
    tbl4[5] = '{8'd0,  8'd15, 1'b0, 9'h011};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    #12;
    checkOutput("rst_busy8", 32'(busy8), 32'd0);
    checkOutput("rst_done8", 32'(done8), 32'd0);
    checkOutput("rst_diff8", 32'(diff8), 32'd0);
    checkOutput("rst_bout8", 32'(bout8), 32'd0);
    checkOutput("rst_busy4", 32'(busy4), 32'd0);
    checkOutput("rst_diff4", 32'(diff4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic latency and busy window for N=8.
    applyStimulus(1'b0, 8'd8, 8'd3, 1'b0, 9'h005, 1'b1);
    waitDone(1'b0, k, bc);
    checkOutput("t1_latency", 32'(k), 32'd9);
    checkOutput("t1_busy_cycles", 32'(bc), 32'd8);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, tbl8[i].a, tbl8[i].b, tbl8[i].bin, tbl8[i].exp, 1'b1);
      waitDone(1'b0, k, bc);
      checkOutput("tbl8_latency", 32'(k), 32'd9);
    end

    // start during RUN must be ignored.
    applyStimulus(1'b0, 8'd200, 8'd100, 1'b0, 9'h064, 1'b1);
    d0 = dones8;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) start8 = 1'b0;
      if (j == 3) begin a8 = 8'd1; b8 = 8'd2; start8 = 1'b1; end
      if (j == 4) start8 = 1'b0;
    end
    repeat (20) @(negedge clk);
    checkOutput("t3_done_count", 32'(dones8 - d0), 32'd1);
    checkOutput("t3_diff_hold", 32'(diff8), 32'd100);

    // Reset in the middle of an operation abandons it.
    applyStimulus(1'b0, 8'd9, 8'd4, 1'b0, 9'h000, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) start8 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("t4_busy", 32'(busy8), 32'd0);
    checkOutput("t4_done", 32'(done8), 32'd0);
    checkOutput("t4_diff", 32'(diff8), 32'd0);
    checkOutput("t4_bout", 32'(bout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'd9, 8'd4, 1'b0, 9'h005, 1'b1);
    waitDone(1'b0, k, bc);
    checkOutput("t4_latency", 32'(k), 32'd9);

    // start held high: back-to-back operations N+1 cycles apart.
    @(negedge clk);
    a8 = 8'd7; b8 = 8'd2; bin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h005); pushes8++;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'd2; b8 = 8'd7;
    q8.push_back(9'h1FB); pushes8++;
    k = 1;
    while (!done8 && k < 40) begin @(negedge clk); k++; end
    checkOutput("t5_first_latency", 32'(k), 32'd9);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
      if (gap == 1) start8 = 1'b0;
    end while (!done8 && gap < 40);
    checkOutput("t5_spacing", 32'(gap), 32'd9);

    // N=4 directed table.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, tbl4[i].a, tbl4[i].b, tbl4[i].bin, tbl4[i].exp, 1'b1);
      waitDone(1'b1, k, bc);
      checkOutput("tbl4_latency", 32'(k), 32'd5);
      checkOutput("tbl4_busy_cycles", 32'(bc), 32'd4);
    end

    // Random regression against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      applyStimulus(1'b0, ra, rb, rbin, model8(ra, rb, rbin), 1'b1);
      waitDone(1'b0, k, bc);
    end
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      rbin = 1'($urandom_range(0, 1));
      applyStimulus(1'b1, ra, rb, rbin, {4'b0, model4(ra[3:0], rb[3:0], rbin)}, 1'b1);
      waitDone(1'b1, k, bc);
    end

    repeat (5) @(negedge clk);
    checkOutput("q8_empty", 32'(q8.size()), 32'd0);
    checkOutput("q4_empty", 32'(q4.size()), 32'd0);
    checkOutput("dones8_vs_pushes", 32'(dones8), 32'(pushes8));
    checkOutput("dones4_vs_pushes", 32'(dones4), 32'(pushes4));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
